lz4_addr_gen_lanes: RTL and testbench

Multi-lane, frame-aware byte address generator for the LZ4 compressor input path. Each accepted beat carries 0..LANES bytes; the block emits one registered address per byte lane (frame-relative and absolute), a lane-valid mask and frame bookkeeping. It sits between the input byte packer and the hash/match stages. It supersedes the single free-running counter with a handshake, frame restart, a head-address offset and error flags.

---
 rtl/lz4_addr_gen_lanes_pkg.sv | 13 +
 rtl/lz4_addr_lane_expand.sv | 27 ++
 rtl/lz4_addr_gen_lanes.sv | 109 ++++++++++
 tb/tb_lz4_addr_gen_lanes.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lz4_addr_gen_lanes_pkg.sv
// Shared defaults and helpers for the LZ4 multi-lane address generator.
package lz4_addr_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned LANES_DEF   = 4;
    localparam int unsigned FRAME_CNT_W = 16;

    // Oversized beats are truncated to the lane count.
    function automatic int unsigned min_inc(input int unsigned incr, input int unsigned lanes);
        return (incr > lanes) ? lanes : incr;
    endfunction

endpackage

// File: rtl/lz4_addr_lane_expand.sv
// Combinational fan-out of a base counter into per-lane relative/absolute addresses and mask.
module lz4_addr_lane_expand
    import lz4_addr_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned INC_W  = $clog2(LANES + 1)
) (
    input  logic [ADDR_W-1:0]       base,
    input  logic [ADDR_W-1:0]       head,
    input  logic [INC_W-1:0]        inc,
    output logic [LANES*ADDR_W-1:0] rel_vec,
    output logic [LANES*ADDR_W-1:0] abs_vec,
    output logic [LANES-1:0]        lane_vld
);

    logic [ADDR_W-1:0] abs_base;

    assign abs_base = head + base;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign rel_vec[i*ADDR_W +: ADDR_W] = base + ADDR_W'(i);
        assign abs_vec[i*ADDR_W +: ADDR_W] = abs_base + ADDR_W'(i);
        assign lane_vld[i]                 = (INC_W'(i) < inc);
    end

endmodule

// File: rtl/lz4_addr_gen_lanes.sv
// Frame-aware multi-lane byte address generator with a 1-deep registered output stage.
module lz4_addr_gen_lanes
    import lz4_addr_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned INC_W  = $clog2(LANES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INC_W-1:0]        incr_bytes,
    input  logic                    in_last,
    input  logic [ADDR_W-1:0]       head_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ADDR_W-1:0] out_rel_addr,
    output logic [LANES*ADDR_W-1:0] out_abs_addr,
    output logic [LANES-1:0]        out_lane_vld,
    output logic                    out_last,
    output logic [FRAME_CNT_W-1:0]  frame_cnt,
    output logic                    wrap_err,
    output logic                    incr_err
);

    localparam logic [INC_W-1:0] LanesW = INC_W'(LANES);

    logic [ADDR_W-1:0]       rel_cnt_q, head_reg_q, head_used;
    logic                    first_beat_q;
    logic                    out_valid_q, out_last_q, wrap_err_q, incr_err_q;
    logic [LANES*ADDR_W-1:0] out_rel_q, out_abs_q, rel_vec, abs_vec;
    logic [LANES-1:0]        out_vld_q, lane_vld;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q;
    logic [INC_W-1:0]        inc;
    logic [ADDR_W:0]         sum;
    logic                    accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign inc       = INC_W'(min_inc(32'(incr_bytes), LANES));
    assign head_used = first_beat_q ? head_addr : head_reg_q;
    // Extra MSB catches the carry out of the relative counter.
    assign sum       = {1'b0, rel_cnt_q} + {{(ADDR_W + 1 - INC_W){1'b0}}, inc};

    lz4_addr_lane_expand #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .INC_W  (INC_W)
    ) u_expand (
        .base     (rel_cnt_q),
        .head     (head_used),
        .inc      (inc),
        .rel_vec  (rel_vec),
        .abs_vec  (abs_vec),
        .lane_vld (lane_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rel_cnt_q    <= '0;
            head_reg_q   <= '0;
            first_beat_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_rel_q    <= '0;
            out_abs_q    <= '0;
            out_vld_q    <= '0;
            out_last_q   <= 1'b0;
            frame_cnt_q  <= '0;
            wrap_err_q   <= 1'b0;
            incr_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_rel_q   <= rel_vec;
            out_abs_q   <= abs_vec;
            out_vld_q   <= lane_vld;
            out_last_q  <= in_last;
            if (incr_bytes > LanesW) begin
                incr_err_q <= 1'b1;
            end
            if (first_beat_q) begin
                head_reg_q <= head_addr;
            end
            if (in_last) begin
                rel_cnt_q    <= '0;
                first_beat_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + 1'b1;
            end else begin
                rel_cnt_q    <= sum[ADDR_W-1:0];
                first_beat_q <= 1'b0;
                if (sum[ADDR_W]) begin
                    wrap_err_q <= 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rel_addr = out_rel_q;
    assign out_abs_addr = out_abs_q;
    assign out_lane_vld = out_vld_q;
    assign out_last     = out_last_q;
    assign frame_cnt    = frame_cnt_q;
    assign wrap_err     = wrap_err_q;
    assign incr_err     = incr_err_q;

endmodule

// File: tb/tb_lz4_addr_gen_lanes.sv
// Directed bench: 32-bit instance for frame/handshake behaviour, 8-bit instance for counter wrap.
module tb_lz4_addr_gen_lanes;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance, ADDR_W=32, LANES=4
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [2:0]  incr_bytes;
    logic [31:0] head_addr;
    logic [127:0] out_rel_addr, out_abs_addr;
    logic [3:0]  out_lane_vld;
    logic [15:0] frame_cnt;
    logic        wrap_err, incr_err;

    // Wrap instance, ADDR_W=8, LANES=4
    logic        in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_last_b;
    logic [2:0]  incr_bytes_b;
    logic [7:0]  head_addr_b;
    logic [31:0] out_rel_addr_b, out_abs_addr_b;
    logic [3:0]  out_lane_vld_b;
    logic [15:0] frame_cnt_b;
    logic        wrap_err_b, incr_err_b;

    lz4_addr_gen_lanes #(.ADDR_W(32), .LANES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .incr_bytes   (incr_bytes),
        .in_last      (in_last),
        .head_addr    (head_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rel_addr (out_rel_addr),
        .out_abs_addr (out_abs_addr),
        .out_lane_vld (out_lane_vld),
        .out_last     (out_last),
        .frame_cnt    (frame_cnt),
        .wrap_err     (wrap_err),
        .incr_err     (incr_err)
    );

    lz4_addr_gen_lanes #(.ADDR_W(8), .LANES(4)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid_b),
        .in_ready     (in_ready_b),
        .incr_bytes   (incr_bytes_b),
        .in_last      (in_last_b),
        .head_addr    (head_addr_b),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready_b),
        .out_rel_addr (out_rel_addr_b),
        .out_abs_addr (out_abs_addr_b),
        .out_lane_vld (out_lane_vld_b),
        .out_last     (out_last_b),
        .frame_cnt    (frame_cnt_b),
        .wrap_err     (wrap_err_b),
        .incr_err     (incr_err_b)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] incr, input logic last, input logic [31:0] head);
        in_valid   = 1'b1;
        incr_bytes = incr;
        in_last    = last;
        head_addr  = head;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; incr_bytes = '0; in_last = 1'b0; head_addr = '0; out_ready = 1'b1;
        in_valid_b = 1'b0; incr_bytes_b = '0; in_last_b = 1'b0; head_addr_b = '0;
        out_ready_b = 1'b1;
        tick();
        tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("rst_rel", out_rel_addr[63:0], 64'd0);
        check_eq("rst_errs", 64'({wrap_err, incr_err}), 64'd0);
        rst = 1'b0;

        beat(3'd4, 1'b0, 32'h1000);
        check_eq("b1_valid", 64'(out_valid), 64'd1);
        check_eq("b1_rel0", 64'(out_rel_addr[31:0]), 64'd0);
        check_eq("b1_abs0", 64'(out_abs_addr[31:0]), 64'h1000);
        check_eq("b1_abs3", 64'(out_abs_addr[127:96]), 64'h1003);
        check_eq("b1_vld", 64'(out_lane_vld), 64'hf);
        // head_addr changes mid-frame must be ignored
        beat(3'd4, 1'b0, 32'hdead);
        check_eq("b2_rel0", 64'(out_rel_addr[31:0]), 64'd4);
        check_eq("b2_abs0", 64'(out_abs_addr[31:0]), 64'h1004);
        beat(3'd3, 1'b0, 32'hbeef);
        check_eq("b3_rel0", 64'(out_rel_addr[31:0]), 64'd8);
        check_eq("b3_abs0", 64'(out_abs_addr[31:0]), 64'h1008);
        check_eq("b3_vld", 64'(out_lane_vld), 64'h7);
        beat(3'd2, 1'b1, 32'h0);
        check_eq("b4_rel0", 64'(out_rel_addr[31:0]), 64'd11);
        check_eq("b4_abs1", 64'(out_abs_addr[63:32]), 64'h100c);
        check_eq("b4_last", 64'(out_last), 64'd1);
        check_eq("b4_frame_cnt", 64'(frame_cnt), 64'd1);

        beat(3'd2, 1'b0, 32'h8000);
        check_eq("f2_rel0", 64'(out_rel_addr[31:0]), 64'd0);
        check_eq("f2_rel1", 64'(out_rel_addr[63:32]), 64'd1);
        check_eq("f2_abs0", 64'(out_abs_addr[31:0]), 64'h8000);
        check_eq("f2_abs1", 64'(out_abs_addr[63:32]), 64'h8001);
        check_eq("f2_last", 64'(out_last), 64'd0);
        check_eq("f2_vld", 64'(out_lane_vld), 64'h3);

        // Backpressure: held beat stays put, offered beat waits
        out_ready = 1'b0;
        in_valid = 1'b1; incr_bytes = 3'd4; in_last = 1'b0; head_addr = 32'h5555;
        #1;
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_abs0", 64'(out_abs_addr[31:0]), 64'h8000);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_rdy", 64'(in_ready), 64'd1);
        tick();
        check_eq("bp_next_rel0", 64'(out_rel_addr[31:0]), 64'd2);
        check_eq("bp_next_abs0", 64'(out_abs_addr[31:0]), 64'h8002);
        in_valid = 1'b0;
        tick();
        check_eq("idle_valid", 64'(out_valid), 64'd0);

        beat(3'd7, 1'b0, 32'h0);
        check_eq("ovr_rel0", 64'(out_rel_addr[31:0]), 64'd6);
        check_eq("ovr_vld", 64'(out_lane_vld), 64'hf);
        check_eq("ovr_err", 64'(incr_err), 64'd1);
        beat(3'd1, 1'b0, 32'h0);
        check_eq("ovr_next_rel0", 64'(out_rel_addr[31:0]), 64'd10);
        check_eq("ovr_next_vld", 64'(out_lane_vld), 64'h1);
        check_eq("ovr_err_sticky", 64'(incr_err), 64'd1);

        beat(3'd0, 1'b0, 32'h0);
        check_eq("zero_valid", 64'(out_valid), 64'd1);
        check_eq("zero_vld", 64'(out_lane_vld), 64'h0);
        check_eq("zero_rel0", 64'(out_rel_addr[31:0]), 64'd11);
        beat(3'd1, 1'b0, 32'h0);
        check_eq("post_zero_rel0", 64'(out_rel_addr[31:0]), 64'd11);
        check_eq("no_wrap", 64'(wrap_err), 64'd0);

        // Mid-frame reset with a beat pending
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("mrst_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("mrst_incr_err", 64'(incr_err), 64'd0);
        check_eq("mrst_rel0", 64'(out_rel_addr[31:0]), 64'd0);
        rst = 1'b0;
        beat(3'd1, 1'b0, 32'h2000);
        check_eq("mrst_new_rel0", 64'(out_rel_addr[31:0]), 64'd0);
        check_eq("mrst_new_abs0", 64'(out_abs_addr[31:0]), 64'h2000);
        in_valid = 1'b0;

        // 8-bit counter wrap
        in_valid_b = 1'b1; incr_bytes_b = 3'd4; in_last_b = 1'b0; head_addr_b = 8'h00;
        for (int b = 0; b < 63; b++) begin
            tick();
        end
        check_eq("w_rel0_248", 64'(out_rel_addr_b[7:0]), 64'd248);
        check_eq("w_pre_err", 64'(wrap_err_b), 64'd0);
        tick();
        check_eq("w_lanes", 64'(out_rel_addr_b), 64'hfffefdfc);
        check_eq("w_err", 64'(wrap_err_b), 64'd1);
        incr_bytes_b = 3'd1;
        tick();
        check_eq("w_next_rel0", 64'(out_rel_addr_b[7:0]), 64'd0);
        check_eq("w_err_sticky", 64'(wrap_err_b), 64'd1);
        check_eq("w_frame_cnt", 64'(frame_cnt_b), 64'd0);
        in_valid_b = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
